tachyon_manifold_ctrl: RTL and testbench
========================================

// Module: tachyon_manifold_ctrl
// PURPOSE
//  Sequencer for tachyon_manifold_sim: accepts an ASCII schematic byte stream (valid/ready), decodes each byte into sim strobes.
//  Owns sim reset, checks stream format, captures the final split count and presents it on a valid/ready result port.
//  Sits between the byte source (UART RX FIFO) and the simulator; one run per start pulse.
// PARAMETERS
//  TACHYON_MANIFOLD_WIDTH  3  chars per line passed to sim; odd, >=3
//  (local) COUNT_W = $clog2(((W**2-1)/8)+1), COL_W = $clog2(W+1), LINE_W = $clog2(W+1)
// PORTS
//  clk                   in   1        single clock
//  reset                 in   1        asynchronous, active-high; whole block
//  start                 in   1        pulse; begins a run (honoured in IDLE/ERROR only)
//  byte_in               in   8        ASCII schematic byte
//  byte_valid            in   1        byte_in valid
//  byte_ready            out  1        accept; high only in RUN
//  sim_reset             out  1        to sim reset
//  sim_beam_empty/_enter/_splitter/_line_feed  out 1 each  one-hot decoded strobes ('.','S','^','\n')
//  sim_beam_in_valid     out  1        strobe qualifier
//  sim_split_count       in   COUNT_W  from sim
//  sim_split_count_valid in   1        from sim
//  result_count          out  COUNT_W  captured split count
//  result_valid          out  1        held until result_ready
//  result_ready          in   1        result consumer accept
//  busy                  out  1        state != IDLE
//  error                 out  1        state == ERROR
//  error_code            out  2        01 bad char, 10 line length, 11 S misplaced; 00 otherwise
// BEHAVIOUR
//  Reset values: byte_ready=0, sim_reset=1, all strobes 0, result_count=0, result_valid=0, busy=0, error=0, error_code=0.
//  FSM: IDLE -start-> CLEAR (1 cycle, sim_reset=1) -> RUN -final valid-> DONE -result_ready-> IDLE. Any check fail in RUN -> ERROR.
//  ERROR -start-> CLEAR (error/error_code cleared on that edge). Start in CLEAR/RUN/DONE ignored.
//  sim_reset=1 in IDLE, CLEAR, ERROR; 0 in RUN, DONE.
//  RUN: byte accepted when byte_valid&byte_ready; strobes registered, appear 1 cycle later with sim_beam_in_valid=1 for exactly 1 cycle.
//  Column counter col increments per non-LF byte; line counter line increments per LF; both cleared in CLEAR.
//  Checks on accepted byte (erroring byte is NOT forwarded to sim): byte not in {'.','S','^','\n'} -> 01;
//   non-LF with col==W, or LF with col!=W -> 10; 'S' on line!=0 or second 'S' -> 11; LF on line 0 with no 'S' seen -> 11.
//  sim_split_count_valid sampled every cycle in RUN; when high, result_count<=sim_split_count, result_valid<=1, -> DONE (byte_ready low from next cycle).
//  Expected: valid fires on forwarded LF of line W-1 (0-based); LF accepted with line==W-1 stops further acceptance (byte_ready=0 until DONE).
//  DONE: result_valid=1 and result_count stable until result_ready; on handshake result_valid<=0 -> IDLE.
//  Simultaneous result_ready & start in DONE: handshake completes, start ignored.
//  Simultaneous check error and sim valid cannot occur (erroring byte never forwarded).
//  Async reset mid-run: immediate return to reset values; sim held in reset; run lost.
// CONFIGURATION
//  TACHYON_CTRL_CR_STRIP_EN defined: '\r' (0x0D) accepted and silently dropped (no strobe, no col change).
//  Not defined: '\r' is a bad char -> ERROR code 01.
// STRUCTURE
//  Package tachyon_pkg: ASCII constants (CH_DOT, CH_S, CH_CARET, CH_LF, CH_CR), state enum
//   {ST_IDLE, ST_CLEAR, ST_RUN, ST_DONE, ST_ERROR}, error-code constants ERR_NONE/ERR_CHAR/ERR_LEN/ERR_START.
//  Sub-module tachyon_char_decoder: combinational byte -> {empty, enter, splitter, line_feed, cr, illegal}.
//  Top holds FSM, col/line counters, S-seen flag, output registers; instantiates nothing else (sim is a sibling).
// TESTING (W=3 unless noted; bench instantiates tachyon_manifold_sim as sibling)
//  1 start; stream ".S.\n...\n.^.\n" -> result_valid=1, result_count=1, 1 cycle after final LF strobe; result_ready -> IDLE, busy=0.
//  2 W=5; stream "..S..\n.....\n..^..\n.....\n.^.^.\n" -> result_count=3.
//  3 ".S.\n..x" -> error=1, error_code=01, 'x' not forwarded, byte_ready=0; start -> CLEAR, error=0.
//  4 ".S..\n" -> error_code=10 on 4th char; "..\n" on line 0 -> error_code=10 at LF.
//  5 "...\n" -> error_code=11 at LF; ".S.\n.S.\n" -> 11 at second 'S'.
//  6 CR stream ".S.\r\n...\r\n.^.\r\n": with TACHYON_CTRL_CR_STRIP_EN -> count 1; without -> error_code=01 on first '\r'.
//  7 reset asserted mid-RUN (after 5 bytes) -> all outputs at reset values same cycle; new start + full stream -> correct count.
//  8 result_ready held low 10 cycles in DONE -> result_valid/result_count stable, start ignored, byte_ready=0.

Source files
------------

// File: rtl/tachyon_manifold_ctrl_pkg.sv
// Package: tachyon_pkg
// Shared definitions for the tachyon manifold controller: the ASCII codes of
// the schematic alphabet, the controller state encoding and the error codes
// reported on error_code.
package tachyon_pkg;

    // Schematic alphabet
    localparam logic [7:0] CH_DOT   = 8'h2E;  // '.'  empty cell
    localparam logic [7:0] CH_S     = 8'h53;  // 'S'  beam entry point
    localparam logic [7:0] CH_CARET = 8'h5E;  // '^'  splitter
    localparam logic [7:0] CH_LF    = 8'h0A;  // '\n' end of line
    localparam logic [7:0] CH_CR    = 8'h0D;  // '\r' optional line-ending noise

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CHAR  = 2'b01;  // byte outside the alphabet
    localparam logic [1:0] ERR_LEN   = 2'b10;  // line too long or too short
    localparam logic [1:0] ERR_START = 2'b11;  // 'S' missing, repeated or off line 0

endpackage

// File: rtl/tachyon_manifold_ctrl_char_decoder.sv
// Module: tachyon_char_decoder
// Purely combinational classifier for one schematic byte.
// Ports:
//   byte_in    in  8  ASCII byte
//   empty      out 1  byte is '.'
//   enter      out 1  byte is 'S'
//   splitter   out 1  byte is '^'
//   line_feed  out 1  byte is '\n'
//   cr         out 1  byte is '\r'
//   illegal    out 1  byte is none of the above
module tachyon_char_decoder
    import tachyon_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       empty,
    output logic       enter,
    output logic       splitter,
    output logic       line_feed,
    output logic       cr,
    output logic       illegal
);

    assign empty     = (byte_in == CH_DOT);
    assign enter     = (byte_in == CH_S);
    assign splitter  = (byte_in == CH_CARET);
    assign line_feed = (byte_in == CH_LF);
    assign cr        = (byte_in == CH_CR);
    // CR is reported separately; whether it is legal is decided by the caller.
    assign illegal   = ~(empty | enter | splitter | line_feed | cr);

endmodule

// File: rtl/tachyon_manifold_ctrl.sv
// Module: tachyon_manifold_ctrl
// Sequencer between a byte source and tachyon_manifold_sim. Each start pulse
// runs one schematic: the sim is held in reset for a cycle, then every
// accepted byte is checked and forwarded as a one-cycle decoded strobe. The
// sim's final split count is captured and offered on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid holds its payload stable until that edge, and ready
// may rise or fall independently of valid.
//
// Optional feature: define TACHYON_CTRL_CR_STRIP_EN to accept and silently
// drop '\r' bytes; without it '\r' is reported as a bad character.
//
// Ports:
//   clk, reset (async, active-high)
//   start                      run request (honoured in IDLE / ERROR)
//   byte_in/byte_valid/byte_ready   schematic byte stream
//   sim_reset                  reset to the sim
//   sim_beam_empty/_enter/_splitter/_line_feed, sim_beam_in_valid  strobes
//   sim_split_count, sim_split_count_valid   final count from the sim
//   result_count/result_valid/result_ready   captured result
//   busy, error, error_code    status
module tachyon_manifold_ctrl
    import tachyon_pkg::*;
#(
    parameter int  TACHYON_MANIFOLD_WIDTH = 3,
    localparam int COUNT_W = $clog2(((TACHYON_MANIFOLD_WIDTH * TACHYON_MANIFOLD_WIDTH - 1) / 8) + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               sim_reset,
    output logic               sim_beam_empty,
    output logic               sim_beam_enter,
    output logic               sim_beam_splitter,
    output logic               sim_beam_line_feed,
    output logic               sim_beam_in_valid,
    input  logic [COUNT_W-1:0] sim_split_count,
    input  logic               sim_split_count_valid,
    output logic [COUNT_W-1:0] result_count,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy,
    output logic               error,
    output logic [1:0]         error_code
);

    localparam int W      = TACHYON_MANIFOLD_WIDTH;
    localparam int COL_W  = $clog2(W + 1);
    localparam int LINE_W = $clog2(W + 1);

    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(W);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(W - 1);

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [LINE_W-1:0]  line;
    logic               s_seen;

    logic d_empty, d_enter, d_splitter, d_lf, d_cr, d_illegal;
    logic bad_char, drop_byte, accept;
    logic [1:0] chk_code;

    tachyon_char_decoder u_decoder (
        .byte_in   (byte_in),
        .empty     (d_empty),
        .enter     (d_enter),
        .splitter  (d_splitter),
        .line_feed (d_lf),
        .cr        (d_cr),
        .illegal   (d_illegal)
    );

`ifdef TACHYON_CTRL_CR_STRIP_EN
    assign bad_char  = d_illegal;
    assign drop_byte = d_cr;
`else
    assign bad_char  = d_illegal | d_cr;
    assign drop_byte = 1'b0;
`endif

    // byte_ready is only ever high in RUN, so this is the RUN acceptance.
    assign accept = byte_valid & byte_ready;

    // Format check of the byte currently offered; priority is
    // bad character, then line length, then entry-point placement.
    always_comb begin
        chk_code = ERR_NONE;
        if (bad_char) begin
            chk_code = ERR_CHAR;
        end else if (drop_byte) begin
            chk_code = ERR_NONE;
        end else if (d_lf) begin
            if (col != COL_FULL)
                chk_code = ERR_LEN;
            else if ((line == '0) && !s_seen)
                chk_code = ERR_START;
        end else begin
            if (col == COL_FULL)
                chk_code = ERR_LEN;
            else if (d_enter && ((line != '0) || s_seen))
                chk_code = ERR_START;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            col                <= '0;
            line               <= '0;
            s_seen             <= 1'b0;
            byte_ready         <= 1'b0;
            sim_reset          <= 1'b1;
            sim_beam_empty     <= 1'b0;
            sim_beam_enter     <= 1'b0;
            sim_beam_splitter  <= 1'b0;
            sim_beam_line_feed <= 1'b0;
            sim_beam_in_valid  <= 1'b0;
            result_count       <= '0;
            result_valid       <= 1'b0;
            busy               <= 1'b0;
            error              <= 1'b0;
            error_code         <= ERR_NONE;
        end else begin
            // Strobes live for exactly one cycle.
            sim_beam_empty     <= 1'b0;
            sim_beam_enter     <= 1'b0;
            sim_beam_splitter  <= 1'b0;
            sim_beam_line_feed <= 1'b0;
            sim_beam_in_valid  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CLEAR;
                        busy  <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    state      <= ST_RUN;
                    col        <= '0;
                    line       <= '0;
                    s_seen     <= 1'b0;
                    sim_reset  <= 1'b0;
                    byte_ready <= 1'b1;
                end

                ST_RUN: begin
                    if (sim_split_count_valid) begin
                        result_count <= sim_split_count;
                        result_valid <= 1'b1;
                        byte_ready   <= 1'b0;
                        state        <= ST_DONE;
                    end else if (accept) begin
                        if (chk_code != ERR_NONE) begin
                            // Offending byte is swallowed, never forwarded.
                            state      <= ST_ERROR;
                            error      <= 1'b1;
                            error_code <= chk_code;
                            byte_ready <= 1'b0;
                            sim_reset  <= 1'b1;
                        end else if (!drop_byte) begin
                            sim_beam_empty     <= d_empty;
                            sim_beam_enter     <= d_enter;
                            sim_beam_splitter  <= d_splitter;
                            sim_beam_line_feed <= d_lf;
                            sim_beam_in_valid  <= 1'b1;
                            if (d_lf) begin
                                col  <= '0;
                                line <= line + LINE_W'(1);
                                // Last line complete: wait for the sim's count.
                                if (line == LINE_LAST)
                                    byte_ready <= 1'b0;
                            end else begin
                                col <= col + COL_W'(1);
                                if (d_enter)
                                    s_seen <= 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        sim_reset    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                ST_ERROR: begin
                    if (start) begin
                        error      <= 1'b0;
                        error_code <= ERR_NONE;
                        state      <= ST_CLEAR;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tachyon_manifold_ctrl.sv
module tb_tachyon_manifold_ctrl;

  localparam int CW3 = 1;  // count width for W=3
  localparam int CW5 = 2;  // count width for W=5

`ifdef TACHYON_CTRL_CR_STRIP_EN
  localparam bit CR_EN = 1'b1;
`else
  localparam bit CR_EN = 1'b0;
`endif

  localparam logic [7:0] C_DOT = 8'h2E;
  localparam logic [7:0] C_S   = 8'h53;
  localparam logic [7:0] C_CAR = 8'h5E;
  localparam logic [7:0] C_LF  = 8'h0A;
  localparam logic [7:0] C_CR  = 8'h0D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- DUT signals ----------------
  logic [7:0] byte_in = 8'h00;
  logic start3 = 0, start5 = 0;
  logic bv3 = 0, bv5 = 0;
  logic rr3 = 0, rr5 = 0;

  logic rdy3, srst3, emp3, ent3, spl3, lf3, siv3, rv3, busy3, err3;
  logic [1:0] code3;
  logic [CW3-1:0] cnt3, scnt3;
  logic scv3;

  logic rdy5, srst5, emp5, ent5, spl5, lf5, siv5, rv5, busy5, err5;
  logic [1:0] code5;
  logic [CW5-1:0] cnt5, scnt5;
  logic scv5;

  tachyon_manifold_ctrl #(.TACHYON_MANIFOLD_WIDTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .byte_in(byte_in), .byte_valid(bv3), .byte_ready(rdy3),
    .sim_reset(srst3),
    .sim_beam_empty(emp3), .sim_beam_enter(ent3), .sim_beam_splitter(spl3),
    .sim_beam_line_feed(lf3), .sim_beam_in_valid(siv3),
    .sim_split_count(scnt3), .sim_split_count_valid(scv3),
    .result_count(cnt3), .result_valid(rv3), .result_ready(rr3),
    .busy(busy3), .error(err3), .error_code(code3)
  );

  tachyon_manifold_ctrl #(.TACHYON_MANIFOLD_WIDTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5),
    .byte_in(byte_in), .byte_valid(bv5), .byte_ready(rdy5),
    .sim_reset(srst5),
    .sim_beam_empty(emp5), .sim_beam_enter(ent5), .sim_beam_splitter(spl5),
    .sim_beam_line_feed(lf5), .sim_beam_in_valid(siv5),
    .sim_split_count(scnt5), .sim_split_count_valid(scv5),
    .result_count(cnt5), .result_valid(rv5), .result_ready(rr5),
    .busy(busy5), .error(err5), .error_code(code5)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Beam-splitting rule: the beam enters at 'S' on row 0 and travels down;
  // a beam hitting '^' is counted once and continues left and right of it.
  function automatic int splits(input logic [24:0] car, input logic [24:0] sm, input int w);
    logic [7:0] beams, nb;
    int cnt;
    beams = '0;
    cnt = 0;
    for (int c = 0; c < w; c++) if (sm[c]) beams[c] = 1'b1;
    for (int r = 1; r < w; r++) begin
      nb = beams;
      for (int c = 0; c < w; c++) begin
        if (car[r*w+c] && beams[c]) begin
          cnt++;
          nb[c] = 1'b0;
          if (c > 0) nb[c-1] = 1'b1;
          if (c < w-1) nb[c+1] = 1'b1;
        end
      end
      beams = nb;
    end
    return cnt;
  endfunction

  // ---------------- stand-in simulators (siblings of the DUT) ----------------
  logic [24:0] car3, sm3, car5, sm5;
  int pos3, lines3, pos5, lines5;

  always @(posedge clk) begin
    if (reset || srst3) begin
      car3 <= '0; sm3 <= '0; pos3 <= 0; lines3 <= 0;
    end else if (siv3) begin
      if (lf3) lines3 <= lines3 + 1;
      else begin
        if (spl3) car3[pos3] <= 1'b1;
        if (ent3) sm3[pos3] <= 1'b1;
        pos3 <= pos3 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset || srst5) begin
      car5 <= '0; sm5 <= '0; pos5 <= 0; lines5 <= 0;
    end else if (siv5) begin
      if (lf5) lines5 <= lines5 + 1;
      else begin
        if (spl5) car5[pos5] <= 1'b1;
        if (ent5) sm5[pos5] <= 1'b1;
        pos5 <= pos5 + 1;
      end
    end
  end

  assign scv3  = siv3 & lf3 & (lines3 == 2);
  assign scnt3 = CW3'(splits(car3, sm3, 3));
  assign scv5  = siv5 & lf5 & (lines5 == 4);
  assign scnt5 = CW5'(splits(car5, sm5, 5));

  // ---------------- controller model ----------------
  logic [7:0] exp_q[$];

  // Walks the stream with the format rules; returns how many bytes the
  // controller consumes, the resulting error code and the final count, and
  // queues the bytes that must reach the sim.
  task automatic model_stream(input string s, input int w, input bit push,
                              output int n_acc, output int code, output int cnt);
    int col, line;
    bit sseen;
    logic [24:0] car, sm;
    logic [7:0] ch;
    col = 0; line = 0; sseen = 0; car = '0; sm = '0;
    n_acc = 0; code = 0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      n_acc++;
      if (ch == C_CR && CR_EN) continue;
      if (!(ch == C_DOT || ch == C_S || ch == C_CAR || ch == C_LF)) begin
        code = 1; break;
      end
      if (ch == C_LF) begin
        if (col != w) begin code = 2; break; end
        if (line == 0 && !sseen) begin code = 3; break; end
        if (push) exp_q.push_back(ch);
        line++; col = 0;
        if (line == w) break;
      end else begin
        if (col == w) begin code = 2; break; end
        if (ch == C_S && (line != 0 || sseen)) begin code = 3; break; end
        if (push) exp_q.push_back(ch);
        if (ch == C_CAR) car[line*w+col] = 1'b1;
        if (ch == C_S) begin sm[line*w+col] = 1'b1; sseen = 1; end
        col++;
      end
    end
    cnt = splits(car, sm, w);
  endtask

  // ---------------- compare process (W=3 instance) ----------------
  int cyc = 0;
  int last_lf3 = 0;
  logic rv3_prev = 1'b0;
  logic [7:0] got_ch, exp_ch;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (siv3) begin
        check("strobe_onehot", 32'($countones({emp3, ent3, spl3, lf3})), 32'd1);
        got_ch = emp3 ? C_DOT : ent3 ? C_S : spl3 ? C_CAR : C_LF;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL strobe_unexpected: got char %0h, expected no strobe", got_ch);
        end else begin
          exp_ch = exp_q.pop_front();
          check("strobe_char", 32'(got_ch), 32'(exp_ch));
        end
        if (lf3) last_lf3 = cyc;
      end else begin
        check("strobe_idle", 32'({emp3, ent3, spl3, lf3}), 32'd0);
      end
      if (rv3 && !rv3_prev) check("result_latency", 32'(cyc - last_lf3), 32'd1);
      if (err3) check("error_quiet", 32'({srst3, rdy3}), 32'b10);
      if (!busy3) check("idle_quiet", 32'({srst3, rdy3, rv3, err3}), 32'b1000);
    end
    rv3_prev = rv3;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit sel5);
    @(posedge clk); #1;
    if (sel5) start5 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; start5 = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] c, input bit sel5, output bit ok);
    byte_in = c;
    if (sel5) bv5 = 1'b1; else bv3 = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (sel5 ? rdy5 : rdy3) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bv3 = 1'b0; bv5 = 1'b0;
  endtask

  task automatic run3(input string s, input int exp_code, input int exp_cnt, input string tag);
    int n_acc, code, cnt;
    bit ok;
    model_stream(s, 3, 1'b1, n_acc, code, cnt);
    check({tag, "_model_code"}, 32'(code), 32'(exp_code));
    if (exp_code == 0) check({tag, "_model_count"}, 32'(cnt), 32'(exp_cnt));
    pulse_start(1'b0);
    for (int i = 0; i < n_acc; i++) begin
      send_byte(s[i], 1'b0, ok);
      if (!ok) begin
        check({tag, "_accept"}, 32'd0, 32'd1);
        break;
      end
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rv3 || err3) break;
    end
    if (code == 0) begin
      check({tag, "_result_valid"}, 32'(rv3), 32'd1);
      check({tag, "_result_count"}, 32'(cnt3), 32'(exp_cnt));
      check({tag, "_ready_low"}, 32'(rdy3), 32'd0);
    end else begin
      check({tag, "_error"}, 32'(err3), 32'd1);
      check({tag, "_error_code"}, 32'(code3), 32'(exp_code));
      check({tag, "_ready_low"}, 32'(rdy3), 32'd0);
      check({tag, "_no_result"}, 32'(rv3), 32'd0);
    end
    check({tag, "_fwd_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic handshake3(input string tag);
    @(posedge clk); #1;
    rr3 = 1'b1;
    @(posedge clk); #1;
    rr3 = 1'b0;
    @(negedge clk);
    check({tag, "_hs_valid"}, 32'(rv3), 32'd0);
    check({tag, "_hs_busy"}, 32'(busy3), 32'd0);
  endtask

  task automatic restart3(input string tag);
    pulse_start(1'b0);
    @(negedge clk);
    check({tag, "_clr_error"}, 32'(err3), 32'd0);
    check({tag, "_clr_code"}, 32'(code3), 32'd0);
    check({tag, "_clr_busy"}, 32'(busy3), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_acc, code, cnt;
    bit ok;
    string s5;

    #1 reset = 1'b1;
    #2;
    check("rst_ready", 32'(rdy3), 32'd0);
    check("rst_sim_reset", 32'(srst3), 32'd1);
    check("rst_strobes", 32'({emp3, ent3, spl3, lf3, siv3}), 32'd0);
    check("rst_result", 32'({cnt3, rv3}), 32'd0);
    check("rst_status", 32'({busy3, err3, code3}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic run and result handshake
    run3(".S.\n...\n.^.\n", 0, 1, "t1");
    handshake3("t1");

    // Bad character; restart clears the error
    run3(".S.\n..x", 1, 0, "t3");
    restart3("t3");

    // Line-length errors
    run3(".S..\n", 2, 0, "t4a");
    restart3("t4a");
    run3("..\n", 2, 0, "t4b");
    restart3("t4b");

    // Entry-point errors
    run3("...\n", 3, 0, "t5a");
    restart3("t5a");
    run3(".S.\n.S.\n", 3, 0, "t5b");
    restart3("t5b");

    // Carriage returns
    if (CR_EN) begin
      run3(".S.\015\n...\015\n.^.\015\n", 0, 1, "t6");
      handshake3("t6");
    end else begin
      run3(".S.\015\n...\015\n.^.\015\n", 1, 0, "t6");
      restart3("t6");
    end

    // Reset in the middle of a run
    pulse_start(1'b0);
    model_stream(".S.\n.", 3, 1'b1, n_acc, code, cnt);
    for (int i = 0; i < 5; i++) send_byte(8'(".S.\n."  >> (8 * (4 - i))), 1'b0, ok);
    #2 reset = 1'b1;
    #1;
    check("t7_ready", 32'(rdy3), 32'd0);
    check("t7_sim_reset", 32'(srst3), 32'd1);
    check("t7_strobes", 32'({emp3, ent3, spl3, lf3, siv3}), 32'd0);
    check("t7_status", 32'({cnt3, rv3, busy3, err3, code3}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    run3(".S.\n...\n.^.\n", 0, 1, "t7b");
    handshake3("t7b");

    // Result held while the consumer stalls; start is ignored in DONE
    run3(".S.\n...\n.^.\n", 0, 1, "t8");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) start3 = 1'b1;
      if (k == 5) start3 = 1'b0;
      check("t8_hold_valid", 32'(rv3), 32'd1);
      check("t8_hold_count", 32'(cnt3), 32'd1);
      check("t8_hold_ready", 32'(rdy3), 32'd0);
      check("t8_hold_busy", 32'(busy3), 32'd1);
    end
    handshake3("t8");

    // W=5 instance
    s5 = "..S..\n.....\n..^..\n.....\n.^.^.\n";
    model_stream(s5, 5, 1'b0, n_acc, code, cnt);
    check("t2_model_code", 32'(code), 32'd0);
    check("t2_model_count", 32'(cnt), 32'd3);
    pulse_start(1'b1);
    for (int i = 0; i < n_acc; i++) begin
      send_byte(s5[i], 1'b1, ok);
      if (!ok) begin
        check("t2_accept", 32'd0, 32'd1);
        break;
      end
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rv5 || err5) break;
    end
    check("t2_result_valid", 32'(rv5), 32'd1);
    check("t2_result_count", 32'(cnt5), 32'd3);
    check("t2_error", 32'(err5), 32'd0);
    @(posedge clk); #1;
    rr5 = 1'b1;
    @(posedge clk); #1;
    rr5 = 1'b0;
    @(negedge clk);
    check("t2_hs_valid", 32'(rv5), 32'd0);
    check("t2_hs_busy", 32'(busy5), 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
